mt_thread_fetch: RTL and testbench
==================================

Name: mt_thread_fetch

Overview:
Instruction-fetch and thread-select stage that sits directly upstream of mt_core's decode/execute path.
- Each cycle, picks the next active hardware thread in round-robin order and issues that thread's PC to a synchronous instruction ROM.
- Delivers the fetched instruction, tagged with thread ID and PC, downstream.
- Accepts branch redirects and halt notifications back from execute.

Parameters:
- NUM_THREADS, 4: number of hardware thread contexts (2..8).
- TID_W, 2: thread-ID width; must equal ceil(log2(NUM_THREADS)).
- ADDR_W, 8: instruction address width (word addressed).
- INSTR_W, 16: instruction width.
- THREAD_STRIDE, 16: reset PC of thread t is t*THREAD_STRIDE (mod 2^ADDR_W).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low (reset when rst==0 at posedge clk).
- stall  in  1  downstream hold; freezes the stage.
- redirect_valid  in  1  execute-stage PC redirect strobe.
- redirect_tid  in  TID_W  thread being redirected.
- redirect_pc  in  ADDR_W  new PC for redirect_tid.
- halt_valid  in  1  execute-stage halt strobe.
- halt_tid  in  TID_W  thread to deactivate.
- imem_en  out  1  ROM read enable; ROM output holds when 0.
- imem_addr  out  ADDR_W  ROM read address (combinational from selection).
- imem_rdata  in  INSTR_W  ROM data, valid one cycle after an enabled read.
- if_valid  out  1  fetched instruction valid.
- if_tid  out  TID_W  thread ID of fetched instruction.
- if_pc  out  ADDR_W  PC of fetched instruction.
- if_instr  out  INSTR_W  equals imem_rdata; meaningful only when if_valid=1.
- all_halted  out  1  registered; 1 when no thread is active.

Behaviour:
- State: pc[t] per thread, active[t] mask, rr_ptr (0..NUM_THREADS-1), output registers if_valid/if_tid/if_pc.
- Reset (rst==0):
  - pc[t] = t*THREAD_STRIDE; active = all ones; rr_ptr = 0.
  - if_valid = 0, if_tid = 0, if_pc = 0, all_halted = 0.
  - Reset overrides all other inputs in the same cycle and aborts any in-flight fetch; if_valid is 0 in the cycle after reset deasserts.
- Eligibility (combinational): elig[t] = active[t] AND NOT (halt_valid AND halt_tid==t).
- Selection: sel = first t with elig[t]=1, searching rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_THREADS. any_elig = OR of elig.
- imem_addr = pc[sel] (0 if none eligible). imem_en = any_elig AND NOT stall.
- Normal cycle (stall=0, any_elig=1):
  - pc[sel] <= pc[sel]+1, wrapping modulo 2^ADDR_W.
  - rr_ptr <= (sel+1) mod NUM_THREADS.
  - if_valid <= 1, if_tid <= sel, if_pc <= pc[sel].
  - Fetch latency is 1 cycle: if_instr is aligned with the registered tag.
- stall=0 and no thread eligible: if_valid <= 0; pc and rr_ptr unchanged.
- stall=1:
  - if_valid, if_tid, if_pc, rr_ptr and the implicit increment are all held.
  - imem_en=0, so the ROM holds if_instr stable.
  - Redirects and halts are still applied during stall.
- Redirect: pc[redirect_tid] <= redirect_pc. This takes priority over the increment when redirect_tid==sel in the same cycle. The fetch issued that cycle still uses the old pc[sel].
- Halt: active[halt_tid] <= 0, effective for selection in the same cycle. Halt and redirect to the same tid in the same cycle: both apply (PC updated, thread inactive). A halted thread is never reactivated except by reset.
- all_halted <= (next active mask == 0).
- Out-of-range tids (>= NUM_THREADS) on redirect or halt are ignored.
- No squash of if_valid on redirect. Interleaving guarantees a thread has at most one instruction in flight when NUM_THREADS >= the pipeline depth.

Test Plan:
1. Reset, then run with NUM_THREADS=4, no stall -> if_tid sequence 0,1,2,3,0,... and if_pc sequence 0,16,32,48,1,17,...; if_instr matches ROM contents at if_pc.
2. Pulse halt_valid, halt_tid=2 while thread 2 would be selected next -> thread 2 never appears; sequence continues 3,0,1,3,...; pc[2] frozen.
3. Assert stall for 3 cycles mid-run -> if_valid, if_tid, if_pc and if_instr constant for those 3 cycles; rotation resumes with the next thread and no fetch is skipped or duplicated.
4. redirect_tid=1, redirect_pc=8'hF0 in the cycle thread 1 is selected -> that fetch shows its old pc; thread 1's next fetch has if_pc=0xF0. Also redirect to 0xFF and let it increment -> wraps to 0x00.
5. Halt threads 0,1,2,3 in successive cycles -> all_halted=1 one cycle after the last halt; if_valid=0 and imem_en=0 thereafter.
6. Drive rst=0 for one cycle during a stall with thread 3 in flight -> next cycle if_valid=0, all PCs at stride values, rotation restarts at thread 0.

Source files
------------

// File: rtl/mt_thread_fetch.sv
`default_nettype none
// ============================================================================
// Module   : mt_thread_fetch
// Brief    : Round-robin thread select and instruction fetch stage. It issues
//            the selected thread's PC to a synchronous ROM and returns the
//            instruction tagged with thread ID and PC. It also applies branch
//            redirects and thread halts that come back from execute.
// Revision : 1.0 - initial release
// ============================================================================
module mt_thread_fetch #(
    parameter int NUM_THREADS   = 4,
    parameter int TID_W         = 2,
    parameter int ADDR_W        = 8,
    parameter int INSTR_W       = 16,
    parameter int THREAD_STRIDE = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [TID_W-1:0]   redirect_tid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt_valid,
    input  logic [TID_W-1:0]   halt_tid,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [TID_W-1:0]   if_tid,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [INSTR_W-1:0] if_instr,
    output logic               all_halted
);

    localparam logic [TID_W:0]   c_nthr = (TID_W+1)'(NUM_THREADS);
    localparam logic [TID_W-1:0] c_last = TID_W'(NUM_THREADS - 1);

    logic [ADDR_W-1:0]      r_pc [NUM_THREADS];
    logic [NUM_THREADS-1:0] r_active;
    logic [TID_W-1:0]       r_rr_ptr;
    logic                   r_if_valid;
    logic [TID_W-1:0]       r_if_tid;
    logic [ADDR_W-1:0]      r_if_pc;
    logic                   r_all_halted;

    logic [NUM_THREADS-1:0]   w_halt_mask;
    logic [NUM_THREADS-1:0]   w_elig;
    logic [2*NUM_THREADS-2:0] w_elig_dbl;
    logic [NUM_THREADS-1:0]   w_rot;
    logic [TID_W-1:0]         w_off;
    logic [TID_W:0]           w_sum;
    logic [TID_W:0]           w_wrap;
    logic [TID_W-1:0]         w_sel;
    logic [TID_W-1:0]         w_rr_next;
    logic                     w_any_elig;
    logic                     w_redir_ok;

    // A halt removes its thread from selection in the same cycle it arrives.
    // Out-of-range halt tids match no thread, so they are ignored.
    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_halt
        assign w_halt_mask[t] = halt_valid && (halt_tid == TID_W'(t));
    end

    assign w_elig     = r_active & ~w_halt_mask;
    assign w_any_elig = |w_elig;

    // Rotate the eligibility vector so bit 0 is the thread at rr_ptr. The
    // lowest set bit is then the round-robin winner's offset from rr_ptr.
    assign w_elig_dbl = {w_elig[NUM_THREADS-2:0], w_elig};
    assign w_rot      = w_elig_dbl[r_rr_ptr +: NUM_THREADS];

    // Priority-encode the lowest eligible offset in the rotated vector.
    always_comb begin
        w_off = '0;
        for (int i = NUM_THREADS - 1; i >= 0; i--) begin
            if (w_rot[i]) w_off = TID_W'(i);
        end
    end

    assign w_sum     = {1'b0, r_rr_ptr} + {1'b0, w_off};
    assign w_wrap    = w_sum - c_nthr;
    assign w_sel     = (w_sum >= c_nthr) ? w_wrap[TID_W-1:0] : w_sum[TID_W-1:0];
    assign w_rr_next = (w_sel == c_last) ? '0 : w_sel + 1'b1;

    assign w_redir_ok = redirect_valid && ({1'b0, redirect_tid} < c_nthr);

    assign imem_en    = w_any_elig && !stall;
    assign imem_addr  = w_any_elig ? r_pc[w_sel] : '0;
    assign if_valid   = r_if_valid;
    assign if_tid     = r_if_tid;
    assign if_pc      = r_if_pc;
    assign if_instr   = imem_rdata;
    assign all_halted = r_all_halted;

    // Per-thread PCs, active mask, rotation pointer and fetch tag registers.
    // The redirect is written after the increment so that it wins on a collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                r_pc[t] <= ADDR_W'(t * THREAD_STRIDE);
            end
            r_active     <= '1;
            r_rr_ptr     <= '0;
            r_if_valid   <= 1'b0;
            r_if_tid     <= '0;
            r_if_pc      <= '0;
            r_all_halted <= 1'b0;
        end else begin
            if (!stall) begin
                if (w_any_elig) begin
                    r_pc[w_sel] <= r_pc[w_sel] + 1'b1;
                    r_rr_ptr    <= w_rr_next;
                    r_if_valid  <= 1'b1;
                    r_if_tid    <= w_sel;
                    r_if_pc     <= r_pc[w_sel];
                end else begin
                    r_if_valid  <= 1'b0;
                end
            end
            if (w_redir_ok) begin
                r_pc[redirect_tid] <= redirect_pc;
            end
            r_active     <= w_elig;
            r_all_halted <= ~|w_elig;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mt_thread_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_mt_thread_fetch
// Brief    : Directed bench for mt_thread_fetch. It uses a behavioural model
//            and an expectation queue, and checks selected points against
//            hand-derived constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mt_thread_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [1:0]  redirect_tid;
    logic [7:0]  redirect_pc;
    logic        halt_valid;
    logic [1:0]  halt_tid;
    logic        imem_en;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        if_valid;
    logic [1:0]  if_tid;
    logic [7:0]  if_pc;
    logic [15:0] if_instr;
    logic        all_halted;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       v;
        logic [1:0] tid;
        logic [7:0] pc;
        logic       allh;
    } exp_t;

    exp_t q[$];

    // Behavioural reference state
    logic [7:0] m_pc [4];
    logic [3:0] m_act;
    int         m_rr;
    logic       m_v;
    logic [1:0] m_tid;
    logic [7:0] m_ipc;
    logic       m_allh;
    bit         m_init = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_f(input logic [7:0] a);
        return {a ^ 8'h5A, a + 8'h33};
    endfunction

    // Synchronous ROM that holds its output while disabled
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= rom_f(imem_addr);
    end

    mt_thread_fetch #(
        .NUM_THREADS(4), .TID_W(2), .ADDR_W(8), .INSTR_W(16), .THREAD_STRIDE(16)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_tid(redirect_tid),
        .redirect_pc(redirect_pc), .halt_valid(halt_valid), .halt_tid(halt_tid),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_tid(if_tid), .if_pc(if_pc),
        .if_instr(if_instr), .all_halted(all_halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Evaluate the model for the inputs currently driven. Check the
    // combinational ROM request, advance the model and queue the outputs
    // that are expected after the edge.
    task automatic model_step();
        logic [3:0] el;
        int         sel;
        bit         any;
        exp_t       e;
        el = m_act;
        if (halt_valid) el[halt_tid] = 1'b0;
        any = (el != 4'b0);
        sel = 0;
        if (any) begin
            sel = m_rr;
            while (!el[sel]) sel = (sel + 1) % 4;
        end
        if (m_init) begin
            chk("imem_en", 32'(imem_en), 32'(any && !stall));
            chk("imem_addr", 32'(imem_addr), any ? 32'(m_pc[sel]) : 32'd0);
        end
        if (!rst) begin
            for (int t = 0; t < 4; t++) m_pc[t] = 8'(t * 16);
            m_act = 4'hF; m_rr = 0; m_v = 1'b0; m_tid = 2'd0; m_ipc = 8'd0;
            m_allh = 1'b0; m_init = 1'b1;
        end else begin
            if (!stall) begin
                if (any) begin
                    m_v = 1'b1; m_tid = 2'(sel); m_ipc = m_pc[sel];
                    m_pc[sel] = m_pc[sel] + 8'd1;
                    m_rr = (sel + 1) % 4;
                end else begin
                    m_v = 1'b0;
                end
            end
            if (redirect_valid) m_pc[redirect_tid] = redirect_pc;
            m_act  = el;
            m_allh = (el == 4'b0);
        end
        e.v = m_v; e.tid = m_tid; e.pc = m_ipc; e.allh = m_allh;
        q.push_back(e);
    endtask

    // One clock: settle the inputs, run the model and compare after the edge
    task automatic cycle();
        exp_t e;
        #1;
        model_step();
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            checks++; errors++;
            $error("FAIL queue_empty observed=0 expected=1");
        end else begin
            e = q.pop_front();
            chk("if_valid", 32'(if_valid), 32'(e.v));
            chk("if_tid", 32'(if_tid), 32'(e.tid));
            chk("if_pc", 32'(if_pc), 32'(e.pc));
            chk("all_halted", 32'(all_halted), 32'(e.allh));
            if (e.v) chk("if_instr", 32'(if_instr), 32'(rom_f(e.pc)));
        end
    endtask

    task automatic expect_fetch(input string tag, input logic [1:0] tid, input logic [7:0] pc);
        chk({tag, "_valid"}, 32'(if_valid), 32'd1);
        chk({tag, "_tid"}, 32'(if_tid), 32'(tid));
        chk({tag, "_pc"}, 32'(if_pc), 32'(pc));
    endtask

    logic [1:0] seq_tid [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [7:0] seq_pc  [6] = '{8'd0, 8'd16, 8'd32, 8'd48, 8'd1, 8'd17};

    initial begin
        rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_tid = 2'd0;
        redirect_pc = 8'd0; halt_valid = 1'b0; halt_tid = 2'd0;

        // Reset state
        cycle();
        cycle();
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_tid", 32'(if_tid), 32'd0);
        chk("rst_pc", 32'(if_pc), 32'd0);
        chk("rst_allh", 32'(all_halted), 32'd0);

        // Plain rotation across all four threads
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            expect_fetch("rot", seq_tid[i], seq_pc[i]);
        end

        // Halt thread 2 while it is the next candidate
        halt_valid = 1'b1; halt_tid = 2'd2;
        cycle();
        expect_fetch("halt2", 2'd3, 8'd49);
        halt_valid = 1'b0;
        cycle(); expect_fetch("h2_a", 2'd0, 8'd2);
        cycle(); expect_fetch("h2_b", 2'd1, 8'd18);
        cycle(); expect_fetch("h2_c", 2'd3, 8'd50);

        // Stall for three cycles, with a redirect applied mid-stall
        stall = 1'b1;
        cycle(); expect_fetch("stall0", 2'd3, 8'd50);
        redirect_valid = 1'b1; redirect_tid = 2'd0; redirect_pc = 8'h40;
        cycle(); expect_fetch("stall1", 2'd3, 8'd50);
        redirect_valid = 1'b0;
        cycle(); expect_fetch("stall2", 2'd3, 8'd50);
        stall = 1'b0;
        cycle(); expect_fetch("resume", 2'd0, 8'h40);

        // Redirect thread 1 in the cycle it is selected
        redirect_valid = 1'b1; redirect_tid = 2'd1; redirect_pc = 8'hF0;
        cycle(); expect_fetch("redir_old", 2'd1, 8'd19);
        redirect_valid = 1'b0;
        cycle();
        cycle();
        cycle(); expect_fetch("redir_new", 2'd1, 8'hF0);

        // Redirect thread 3 to 0xFF and let it wrap
        redirect_valid = 1'b1; redirect_tid = 2'd3; redirect_pc = 8'hFF;
        cycle(); expect_fetch("r3_old", 2'd3, 8'd52);
        redirect_valid = 1'b0;
        cycle();
        cycle();
        cycle(); expect_fetch("r3_ff", 2'd3, 8'hFF);
        cycle();
        cycle();
        cycle(); expect_fetch("r3_wrap", 2'd3, 8'h00);

        // Reset during a stall with thread 3 in flight
        stall = 1'b1;
        cycle(); expect_fetch("pre_rst", 2'd3, 8'h00);
        rst = 1'b0;
        cycle();
        chk("mid_rst_valid", 32'(if_valid), 32'd0);
        rst = 1'b1; stall = 1'b0;
        cycle(); expect_fetch("post_rst0", 2'd0, 8'd0);
        cycle(); expect_fetch("post_rst1", 2'd1, 8'd16);

        // Halt every thread on successive cycles
        halt_valid = 1'b1;
        halt_tid = 2'd0; cycle(); expect_fetch("hall0", 2'd2, 8'd32);
        halt_tid = 2'd1; cycle(); expect_fetch("hall1", 2'd3, 8'd48);
        halt_tid = 2'd2; cycle(); expect_fetch("hall2", 2'd3, 8'd49);
        chk("allh_before", 32'(all_halted), 32'd0);
        halt_tid = 2'd3; cycle();
        chk("allh_set", 32'(all_halted), 32'd1);
        chk("allh_valid", 32'(if_valid), 32'd0);
        halt_valid = 1'b0;
        cycle();
        chk("idle_en", 32'(imem_en), 32'd0);
        chk("idle_valid", 32'(if_valid), 32'd0);
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
